// File: rtl/gate_sweep_if.sv
// gate_sweep_if
// Signals between the gate sweep checker and the gate under test plus
// the sweep control and result signals.
//   start     : begin a sweep (environment -> checker)
//   C         : gate output under test (gate -> checker)
//   A, B      : gate inputs, vector index bits 1 and 0 (checker -> gate)
//   busy      : sweep in progress
//   done      : sweep finished, results valid
//   pass      : done with no mismatching vectors
//   err_count : number of mismatching vectors, 0..4
//   fail_vec  : bit i set if vector i mismatched
// Modports: master = checker side, slave = gate/environment side.
interface gate_sweep_if;
  logic       start;
  logic       C;
  logic       A;
  logic       B;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  modport master (
    input  start, C,
    output A, B, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, C,
    input  A, B, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
// Drives the four {A,B} combinations onto a 2-input gate, holds each for
// SETTLE+1 cycles, samples C on the last cycle of each hold and compares
// it against TRUTH[{A,B}]. Reports busy/done/pass, a mismatch count and a
// per-vector failure mask.
// Parameters:
//   TRUTH  : expected C per vector, bit i for {A,B} = i (default AND)
//   SETTLE : extra hold cycles per vector, 0..15
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : gate_sweep_if.master (start, C in; A, B, busy, done, pass,
//         err_count, fail_vec out)
module gate_sweep_checker #(
  parameter logic [3:0]  TRUTH  = 4'b1000,
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  gate_sweep_if.master bus
);

  localparam logic [3:0] SETTLE_C = SETTLE[3:0];

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       mismatch;
  logic [2:0] err_next;

  // Compare against the expected value of the vector currently driven;
  // err_next lets pass be decided in the same edge as the last sample.
  assign mismatch = (bus.C != TRUTH[idx]);
  assign err_next = bus.err_count + {2'b00, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      cnt           <= 4'd0;
      bus.A         <= 1'b0;
      bus.B         <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= 3'd0;
      bus.fail_vec  <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state         <= HOLD;
            idx           <= 2'd0;
            cnt           <= 4'd0;
            bus.A         <= 1'b0;
            bus.B         <= 1'b0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.err_count <= 3'd0;
            bus.fail_vec  <= 4'd0;
          end
        end
        HOLD: begin
          if (cnt == SETTLE_C) begin
            if (mismatch) begin
              bus.err_count     <= err_next;
              bus.fail_vec[idx] <= 1'b1;
            end
            if (idx != 2'd3) begin
              idx   <= idx + 2'd1;
              cnt   <= 4'd0;
              {bus.A, bus.B} <= idx + 2'd1;
            end else begin
              // A/B stay at 1,1 through DONE
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (err_next == 3'd0);
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker
// Directed bench for gate_sweep_checker: dut0 (SETTLE=2) sees a selectable
// gate behaviour (AND, OR, constant 1); dut1 (SETTLE=0) sees an AND gate.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;  // 0: AND, 1: OR, 2: C tied to 1

  always #5 clk = ~clk;

  gate_sweep_if bus0 ();
  gate_sweep_if bus1 ();

  assign bus0.C = (mode == 0) ? (bus0.A & bus0.B) :
                  (mode == 1) ? (bus0.A | bus0.B) : 1'b1;
  assign bus1.C = bus1.A & bus1.B;

  gate_sweep_checker #(.TRUTH(4'b1000), .SETTLE(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  gate_sweep_checker #(.TRUTH(4'b1000), .SETTLE(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected C of the gate attached to dut0 for vector v = {A,B}
  function automatic logic model_c(input int m, input int v);
    logic a, b;
    a = v[1];
    b = v[0];
    if (m == 0) return a & b;
    if (m == 1) return a | b;
    return 1'b1;
  endfunction

  // Expected err_count of dut0 after edge E0+k (SETTLE=2, TRUTH=AND)
  function automatic int exp_err(input int m, input int k);
    logic [3:0] truth;
    int n;
    truth = 4'b1000;
    n = 0;
    for (int v = 0; v < 4; v++)
      if ((v + 1) * 3 <= k && model_c(m, v) != truth[v]) n++;
    return n;
  endfunction

  task automatic check_reset0(input string tag);
    chk({tag, "_A"}, bus0.A, 0);
    chk({tag, "_B"}, bus0.B, 0);
    chk({tag, "_busy"}, bus0.busy, 0);
    chk({tag, "_done"}, bus0.done, 0);
    chk({tag, "_pass"}, bus0.pass, 0);
    chk({tag, "_err"}, bus0.err_count, 0);
    chk({tag, "_fv"}, bus0.fail_vec, 0);
  endtask

  // Full sweep on dut0. Optional extra start pulse at E0+pulse_at, or
  // reset at E0+rst_at (sweep abandoned). Start is sampled at edge E0.
  task automatic sweep0(input string tag, input int pulse_at, input int rst_at,
                        input int f_pass, input int f_err, input int f_fv);
    bus0.start = 1'b1;
    tick();  // E0
    bus0.start = 1'b0;
    chk({tag, "_busy0"}, bus0.busy, 1);
    chk({tag, "_done0"}, bus0.done, 0);
    chk({tag, "_ab0"}, {bus0.A, bus0.B}, 0);
    for (int k = 1; k <= 12; k++) begin
      bus0.start = (k == pulse_at);
      rst = (k == rst_at);
      tick();
      bus0.start = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0;
        check_reset0({tag, "_rst"});
        return;
      end
      chk({tag, "_err_k"}, bus0.err_count, exp_err(mode, k));
      if (k < 12) begin
        chk({tag, "_ab_k"}, {bus0.A, bus0.B}, k / 3);
        chk({tag, "_busy_k"}, bus0.busy, 1);
        chk({tag, "_done_k"}, bus0.done, 0);
      end
    end
    chk({tag, "_done"}, bus0.done, 1);
    chk({tag, "_busy"}, bus0.busy, 0);
    chk({tag, "_ab"}, {bus0.A, bus0.B}, 3);
    chk({tag, "_pass"}, bus0.pass, f_pass);
    chk({tag, "_err"}, bus0.err_count, f_err);
    chk({tag, "_fv"}, bus0.fail_vec, f_fv);
  endtask

  initial begin
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset0("reset");
    chk("reset1_done", bus1.done, 0);
    chk("reset1_busy", bus1.busy, 0);

    // AND attached: clean sweep
    mode = 0;
    sweep0("and", 0, 0, 1, 0, 4'b0000);
    tick();
    chk("and_hold_done", bus0.done, 1);
    chk("and_hold_err", bus0.err_count, 0);

    // OR attached, started from DONE: vectors 1 and 2 mismatch
    mode = 1;
    sweep0("or", 0, 0, 0, 2, 4'b0110);

    // C tied to 1: vectors 0, 1, 2 mismatch
    mode = 2;
    sweep0("one", 0, 0, 0, 3, 4'b0111);

    // start during HOLD is ignored
    mode = 0;
    sweep0("ign", 4, 0, 1, 0, 4'b0000);

    // reset mid-sweep, then a full sweep from vector 0
    mode = 2;
    sweep0("rst", 0, 5, 0, 0, 0);
    tick();
    check_reset0("rst_idle");
    mode = 0;
    sweep0("after", 0, 0, 1, 0, 4'b0000);

    // SETTLE=0: one cycle per vector
    bus1.start = 1'b1;
    tick();  // E0
    bus1.start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("s0_ab", {bus1.A, bus1.B}, k);
      chk("s0_done", bus1.done, 0);
    end
    tick();
    chk("s0_done4", bus1.done, 1);
    chk("s0_pass", bus1.pass, 1);
    chk("s0_busy", bus1.busy, 0);

    // restart from DONE clears results for one sweep
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    chk("s0r_done", bus1.done, 0);
    chk("s0r_busy", bus1.busy, 1);
    chk("s0r_pass", bus1.pass, 0);
    chk("s0r_ab", {bus1.A, bus1.B}, 0);
    for (int k = 1; k <= 3; k++) tick();
    chk("s0r_done3", bus1.done, 0);
    tick();
    chk("s0r_done4", bus1.done, 1);
    chk("s0r_pass4", bus1.pass, 1);
    chk("s0r_err", bus1.err_count, 0);
    chk("s0r_fv", bus1.fail_vec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
